// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, FSM state type and lane helper for dmem_responder
package dmem_pkg;

    localparam int DW   = 16;
    localparam int VLEN = 4;
    localparam int LW   = $clog2(VLEN);

    typedef enum logic {IDLE, VBURST} state_t;

    function automatic logic [DW-1:0] lane_slice(input logic [VLEN*DW-1:0] v,
                                                  input logic [LW-1:0]      i);
        return v[int'(i)*DW +: DW];
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between execute stage and dmem_responder
interface dmem_if;
    import dmem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic                 req_vec;
    logic [15:0]          req_addr;
    logic [DW-1:0]        req_wdata;
    logic [VLEN*DW-1:0]   req_vwdata;
    logic                 flush;
    logic                 rsp_valid;
    logic                 rsp_vec;
    logic [DW-1:0]        rsp_rdata;
    logic [VLEN*DW-1:0]   rsp_vrdata;

    modport master (
        output req_valid, req_we, req_vec, req_addr, req_wdata, req_vwdata, flush,
        input  req_ready, rsp_valid, rsp_vec, rsp_rdata, rsp_vrdata
    );

    modport slave (
        input  req_valid, req_we, req_vec, req_addr, req_wdata, req_vwdata, flush,
        output req_ready, rsp_valid, rsp_vec, rsp_rdata, rsp_vrdata
    );

endinterface

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port synchronous RAM, one read or write per cycle, 1-cycle read latency
module dmem_sram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - scalar/vector load-store responder with burst sequencer and in-order responses
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic clk,
    input  logic rst_n,
    dmem_if.slave bus
);

    state_t                 state, state_nx;
    logic [LW-1:0]          lane_cnt, lane_nx;
    logic [AW-1:0]          base_addr;
    logic                   lat_we;
    logic [VLEN*DW-1:0]     lat_vwdata;

    logic                   accept;
    logic                   issue, issue_vec;
    logic [LW-1:0]          issue_lane;
    logic                   ram_we;
    logic [AW-1:0]          ram_addr;
    logic [DW-1:0]          ram_wdata, ram_q;

    logic                   tok_valid, tok_vec;
    logic [LW-1:0]          tok_lane;
    logic [(VLEN-1)*DW-1:0] asm_data;
    logic [VLEN-2:0]        asm_vld;

    logic                   rsp_valid_q, rsp_vec_q;
    logic [DW-1:0]          rsp_rdata_q;
    logic [VLEN*DW-1:0]     rsp_vrdata_q;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[15:AW];

    assign bus.req_ready  = (state == IDLE);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_vec    = rsp_vec_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_vrdata = rsp_vrdata_q;

    dmem_sram #(.AW(AW), .DW(DW)) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // Lane 0 goes out from the live request; later lanes replay the latched request.
    always_comb begin
        state_nx   = state;
        lane_nx    = lane_cnt;
        issue      = 1'b0;
        issue_vec  = 1'b0;
        issue_lane = '0;
        ram_we     = 1'b0;
        ram_addr   = bus.req_addr[AW-1:0];
        ram_wdata  = bus.req_wdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    issue     = 1'b1;
                    issue_vec = bus.req_vec;
                    ram_we    = bus.req_we;
                    if (bus.req_vec) begin
                        ram_wdata = lane_slice(bus.req_vwdata, '0);
                        // A vector load squashed in its own accept cycle never starts a burst.
                        if (bus.req_we || !bus.flush) begin
                            state_nx = VBURST;
                            lane_nx  = LW'(1);
                        end
                    end
                end
            end
            VBURST: begin
                issue      = 1'b1;
                issue_vec  = 1'b1;
                issue_lane = lane_cnt;
                ram_we     = lat_we;
                ram_addr   = base_addr + AW'(lane_cnt);
                ram_wdata  = lane_slice(lat_vwdata, lane_cnt);
                if (lane_cnt == LW'(VLEN-1) || (bus.flush && !lat_we)) begin
                    state_nx = IDLE;
                    lane_nx  = '0;
                end else begin
                    lane_nx = lane_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                lane_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lane_cnt     <= '0;
            base_addr    <= '0;
            lat_we       <= 1'b0;
            lat_vwdata   <= '0;
            tok_valid    <= 1'b0;
            tok_vec      <= 1'b0;
            tok_lane     <= '0;
            asm_data     <= '0;
            asm_vld      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_vec_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_vrdata_q <= '0;
        end else begin
            state    <= state_nx;
            lane_cnt <= lane_nx;
            if (accept) begin
                base_addr  <= bus.req_addr[AW-1:0];
                lat_we     <= bus.req_we;
                lat_vwdata <= bus.req_vwdata;
            end
            tok_valid   <= issue && !ram_we && !bus.flush;
            tok_vec     <= issue_vec;
            tok_lane    <= issue_lane;
            rsp_valid_q <= 1'b0;
            // The token in flight this cycle targets the next cycle's response, so flush drops it too.
            if (bus.flush) begin
                asm_vld <= '0;
            end else if (tok_valid) begin
                if (!tok_vec) begin
                    rsp_valid_q <= 1'b1;
                    rsp_vec_q   <= 1'b0;
                    rsp_rdata_q <= ram_q;
                end else if (tok_lane == LW'(VLEN-1)) begin
                    asm_vld <= '0;
                    if (&asm_vld) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_vec_q    <= 1'b1;
                        rsp_vrdata_q <= {ram_q, asm_data};
                    end
                end else begin
                    asm_data[int'(tok_lane)*DW +: DW] <= ram_q;
                    asm_vld[tok_lane]                 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized bench with a queue-based reference model
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus();
    dmem_responder #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int                 due;
        logic               vec;
        logic [VLEN*DW-1:0] data;
    } exp_t;

    exp_t               exp_q[$];
    logic [DW-1:0]      mem_m [DEPTH];
    int                 cyc;
    int                 busy_until;
    bit                 in_vload;
    logic               last_vec;
    logic [DW-1:0]      last_r;
    logic [VLEN*DW-1:0] last_vr;
    int                 tests;
    int                 fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic cycle_check();
        exp_t e;
        logic exp_v;
        exp_v = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_v = 1'b1;
            last_vec = e.vec;
            if (e.vec) last_vr = e.data;
            else       last_r  = e.data[DW-1:0];
        end
        chk("rsp_valid",  64'(bus.rsp_valid),  64'(exp_v));
        chk("rsp_vec",    64'(bus.rsp_vec),    64'(last_vec));
        chk("rsp_rdata",  64'(bus.rsp_rdata),  64'(last_r));
        chk("rsp_vrdata", 64'(bus.rsp_vrdata), 64'(last_vr));
        chk("req_ready",  64'(bus.req_ready),  64'(cyc >= busy_until));
    endtask

    task automatic drive(input bit v, input bit we, input bit vec, input int addr,
                         input logic [DW-1:0] wd, input logic [VLEN*DW-1:0] vwd,
                         input bit fl, output bit acc);
        exp_t e;
        int   a;
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_vec    = vec;
        bus.req_addr   = 16'(addr);
        bus.req_wdata  = wd;
        bus.req_vwdata = vwd;
        bus.flush      = fl;
        a   = addr % DEPTH;
        acc = v && (cyc >= busy_until);
        if (fl) begin
            exp_q.delete();
            if (in_vload && busy_until > cyc + 1) busy_until = cyc + 1;
        end
        if (acc) begin
            e.data = '0;
            if (!vec) begin
                if (we) mem_m[a] = wd;
                else if (!fl) begin
                    e.due = cyc + 2; e.vec = 1'b0; e.data[DW-1:0] = mem_m[a];
                    exp_q.push_back(e);
                end
            end else if (we) begin
                for (int i = 0; i < VLEN; i++) mem_m[(a + i) % DEPTH] = vwd[i*DW +: DW];
                busy_until = cyc + VLEN;
                in_vload   = 1'b0;
            end else if (!fl) begin
                e.due = cyc + VLEN + 1; e.vec = 1'b1;
                for (int i = 0; i < VLEN; i++) e.data[i*DW +: DW] = mem_m[(a + i) % DEPTH];
                exp_q.push_back(e);
                busy_until = cyc + VLEN;
                in_vload   = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        cycle_check();
    endtask

    task automatic issue(input bit we, input bit vec, input int addr,
                         input logic [DW-1:0] wd, input logic [VLEN*DW-1:0] vwd);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 16 && !acc; k++) drive(1'b1, we, vec, addr, wd, vwd, 1'b0, acc);
        chk("issue_accepted", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0, acc);
    endtask

    initial begin
        bit                 acc;
        bit                 v, we, vec, fl;
        int                 addr;
        logic [DW-1:0]      save [1:3];
        logic [VLEN*DW-1:0] rnd;

        tests = 0; fails = 0; cyc = 0; busy_until = 0; in_vload = 1'b0;
        last_vec = 1'b0; last_r = '0; last_vr = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_vec = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_vwdata = '0; bus.flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        cycle_check();
        #2 rst_n = 1'b1;

        // Fill all of memory so every later load has a defined expected value.
        for (int b = 0; b < DEPTH / VLEN; b++) begin
            rnd = {$urandom, $urandom};
            issue(1'b1, 1'b1, b * VLEN, '0, rnd);
        end
        idle(2);

        // Scalar store then read-after-write load.
        issue(1'b1, 1'b0, 16'h010, 16'hBEEF, '0);
        issue(1'b0, 1'b0, 16'h010, '0, '0);
        idle(3);

        // Vector store/load across the top-of-memory wrap.
        issue(1'b1, 1'b1, 16'h3FE, '0, {16'd4, 16'd3, 16'd2, 16'd1});
        issue(1'b0, 1'b1, 16'h3FE, '0, '0);
        issue(1'b0, 1'b0, 16'h3FF, '0, '0);
        issue(1'b0, 1'b0, 16'h000, '0, '0);
        issue(1'b0, 1'b0, 16'h001, '0, '0);
        idle(6);

        // Back-to-back scalar loads.
        for (int i = 0; i < 8; i++) issue(1'b0, 1'b0, i, '0, '0);
        idle(3);

        // Vector load flushed two cycles into the burst, then a normal scalar load.
        issue(1'b0, 1'b1, 16'h040, '0, '0);
        drive(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0, acc);
        drive(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b1, acc);
        idle(6);
        issue(1'b0, 1'b0, 16'h041, '0, '0);
        idle(3);

        // Reset pulsed one cycle into a vector store.
        for (int i = 1; i <= 3; i++) save[i] = mem_m[16'h020 + i];
        issue(1'b1, 1'b1, 16'h020, '0, {16'hD003, 16'hD002, 16'hD001, 16'hD000});
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        #1;
        chk("rst_rsp_valid",  64'(bus.rsp_valid),  64'(0));
        chk("rst_rsp_vec",    64'(bus.rsp_vec),    64'(0));
        chk("rst_rsp_rdata",  64'(bus.rsp_rdata),  64'(0));
        chk("rst_rsp_vrdata", 64'(bus.rsp_vrdata), 64'(0));
        chk("rst_req_ready",  64'(bus.req_ready),  64'(1));
        for (int i = 1; i <= 3; i++) mem_m[16'h020 + i] = save[i];
        exp_q.delete();
        last_vec = 1'b0; last_r = '0; last_vr = '0; in_vload = 1'b0;
        @(posedge clk);
        cyc++;
        busy_until = cyc;
        #2 rst_n = 1'b1;
        issue(1'b0, 1'b1, 16'h020, '0, '0);
        idle(6);

        // A scalar store held while stalled must not write; then read the word instead.
        issue(1'b1, 1'b1, 16'h100, '0, {$urandom, $urandom});
        while (cyc < busy_until) drive(1'b1, 1'b1, 1'b0, 16'h200, 16'hAAAA, '0, 1'b0, acc);
        issue(1'b0, 1'b0, 16'h200, '0, '0);
        idle(3);

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 99) < 80);
            we   = 1'($urandom_range(0, 1));
            vec  = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 65535);
            fl   = ($urandom_range(0, 19) == 0);
            if (fl && v && vec && !we && cyc >= busy_until) fl = 1'b0;
            drive(v, we, vec, addr, 16'($urandom), {$urandom, $urandom}, fl, acc);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the vector core's execute/writeback pipe. It serves the scalar and vector load/store requests that the execute stage initiates and returns read data aligned to the writeback stage, two cycles after a scalar request. It sequences 4-lane vector accesses over a single-port RAM and stalls the requester while a burst is in flight. A pipeline flush squashes read responses that have not yet been delivered.

## Interface
- AW, 10, word-address width; RAM depth is 2**AW 16-bit words
- DW, 16, data word width
- VLEN, 4, lanes per vector access
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present this cycle
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_vec  input  1  1 = vector (VLEN lanes), 0 = scalar
- req_addr  input  16  word address; only bits [AW-1:0] are used
- req_wdata  input  DW  scalar store data
- req_vwdata  input  VLEN*DW  vector store data; lane i is bits [i*DW +: DW]
- flush  input  1  squash all undelivered read responses
- rsp_valid  output  1  one-cycle pulse; read data valid
- rsp_vec  output  1  response belongs to a vector load
- rsp_rdata  output  DW  scalar load data
- rsp_vrdata  output  VLEN*DW  vector load data, lane order as req_vwdata

## Operation
- Accept occurs on a cycle where req_valid && req_ready. req_valid without req_ready is ignored and has no side effect.
- req_ready is 1 exactly when the FSM is in IDLE.
- FSM states:
  - IDLE: an accepted vector request moves the FSM to VBURST with lane counter 1.
  - VBURST: lane counter increments each cycle; the FSM returns to IDLE after lane VLEN-1 is issued.
- Lane i address is (req_addr + i) mod 2**AW, so the address wraps from top of memory to 0.
- Lane 0 is issued in the accept cycle from the live inputs. Lanes 1..VLEN-1 use the address, we and vwdata latched at accept.
- Store: the RAM word is updated at the end of the cycle its lane issues. A store produces no response.
- Load: the RAM is synchronous, with 1-cycle read latency.
  - Scalar: data is registered one cycle later and presented with rsp_valid.
  - Vector: lanes accumulate into a VLEN*DW assembly register. rsp_valid is raised once, after the last lane has been captured.
- Responses are delivered in request order. A scalar load accepted right after a burst cannot overtake the vector response.
- flush:
  - Clears every pending scalar/vector read token and the assembly register's valid state; no rsp_valid pulse follows for any load accepted at or before the flush cycle.
  - Aborts an in-progress vector load burst: the FSM returns to IDLE on the next edge.
  - Does not abort a vector store burst; the remaining lanes are written.
  - flush and accept in the same cycle: the new request is itself squashed if it is a load. A store still executes.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- RAM contents are not reset.
- rsp_rdata and rsp_vrdata hold their last value when rsp_valid=0.

## Timing
- Reset values: rsp_valid=0, rsp_vec=0, rsp_rdata=0, rsp_vrdata=0. req_ready=1 (IDLE). Lane counter 0; all pending tokens cleared.
- Scalar load accepted in cycle T: rsp_valid=1 in cycle T+2. Sustained throughput is one scalar load or store per cycle.
- Vector request accepted in cycle T:
  - lanes issue in T..T+VLEN-1; req_ready=0 in T+1..T+VLEN-1 and 1 in T+VLEN.
  - for a load, rsp_valid=1 with rsp_vec=1 in T+VLEN+1 (T+5 for VLEN=4).
- Reset asserted mid-burst: the FSM goes to IDLE immediately. Unissued store lanes are not written. No response is produced for in-flight loads.

## Structure
- Package dmem_pkg holds:
  - DW and VLEN constants
  - the FSM state enum {IDLE, VBURST}
  - a lane-slice helper function
- One sub-module, dmem_sram: single-port synchronous RAM, 2**AW x DW, with one read or write per cycle. The responder owns the FSM, address/data latches, response token pipeline and vector assembly register.

## Test plan
- Scalar store 0xBEEF to 0x010, then scalar load of 0x010 on the next cycle -> rsp_valid exactly 2 cycles after the load accept, rsp_rdata=0xBEEF, rsp_vec=0.
- Vector store {1,2,3,4} at 0x3FE (AW=10), then vector load at 0x3FE -> words 0x3FE, 0x3FF, 0x000, 0x001 hold 1..4. The load returns rsp_vrdata lanes {1,2,3,4} at accept+5. req_ready is low for 3 cycles after each accept.
- Scalar loads of 0x000..0x007 on 8 consecutive cycles -> 8 consecutive rsp_valid pulses with data in address order; req_ready stays 1.
- Vector load accepted at T with flush asserted at T+2 -> no rsp_valid in T+3..T+8; req_ready=1 at T+3. A subsequent scalar load responds normally.
- Vector store at 0x020 with rst_n pulsed low at accept+1 -> 0x020 written, 0x021..0x023 unchanged. Outputs take their reset values while rst_n is low.
- req_valid held with a scalar store while req_ready=0 during a burst -> target word unchanged until the request is re-presented after req_ready returns to 1.
